countdown_mmss: RTL and testbench
=================================

# countdown_mmss

Loadable BCD MM:SS countdown timer that decrements once per external 1 Hz `tick` and raises a one-cycle `done` pulse on reaching 00:00. It is the down-counting counterpart of the timer's mod-60 up-counter chain. The block is driven by the same tick generator and feeds the same seven-segment display path. A control FSM handles load, start, pause and clear.

## Interface
- `MIN_MAX`, default 59: highest loadable minute value, as a decimal number 0..99.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `tick` input, 1 bit: one-cycle count-enable pulse, nominally 1 Hz.
- `load` input, 1 bit: latches `ld_min_t`, `ld_min_u`, `ld_sec_t` and `ld_sec_u` into both the count and the preset.
- `ld_min_t`, `ld_min_u`, `ld_sec_t`, `ld_sec_u` input, 4 bits each: BCD load digits (tens and units).
- `start` input, 1 bit: begin or resume counting.
- `pause` input, 1 bit: suspend counting.
- `clear` input, 1 bit: zero the count and go idle. The preset is retained.
- `min_q1`, `min_q2`, `sec_q1`, `sec_q2` output, 4 bits each: current count as BCD; `q1` is tens, `q2` is units.
- `running` output, 1 bit: high in RUN.
- `paused` output, 1 bit: high in PAUSE.
- `done` output, 1 bit: one-cycle pulse when the count reaches 00:00.
- `load_err` output, 1 bit: one-cycle pulse when a load is rejected.

## Operation
- **FSM states:** IDLE, RUN, PAUSE, DONE.
- **Reset:** state IDLE; all digits, the preset, `running`, `paused`, `done` and `load_err` are 0.
- **Per-cycle priority:** `clear` > `load` > `pause` > `start` > `tick`. Only the highest-priority asserted request acts in a cycle.
- **clear:** any state → IDLE; count becomes 00:00.
- **load:**
  - Accepted in IDLE, PAUSE and DONE. In RUN it is ignored, with no `load_err`.
  - The load is valid only if:
    - all digits ≤ 9;
    - `ld_sec_t` ≤ 5;
    - 10·`ld_min_t` + `ld_min_u` ≤ `MIN_MAX`.
  - If valid: count and preset take the digits, and the state becomes IDLE.
  - If invalid: count, preset and state are unchanged, and `load_err` pulses.
- **start:** IDLE or PAUSE → RUN only if the count ≠ 00:00. Otherwise start is ignored. Start is ignored in DONE and RUN.
- **pause:** RUN → PAUSE; ignored in all other states.
- **tick in RUN:** decrement by one second with a BCD borrow chain:
  - `sec_q2` 0 → 9, borrowing from `sec_q1`;
  - `sec_q1` 0 → 5, borrowing from `min_q2`;
  - `min_q2` 0 → 9, borrowing from `min_q1`.
- **Terminal count:** a tick at 00:01 produces 00:00, pulses `done`, and moves RUN → DONE (autoreload behaviour is under Configuration).
- **Ticks outside RUN** are ignored.
- **Arithmetic:** all arithmetic is per-digit, 4-bit. No binary conversion is used except the load range check.

## Timing
- All outputs are registered. The count, state and flags update on the same `clk` edge that samples the request.
- `done` is high in exactly the cycle in which the outputs first show 00:00.
- A `tick` coincident with `start` does not decrement. The first decrement happens on the next tick after RUN is entered.
- A `tick` coincident with `pause` does not decrement.
- A `tick` coincident with `load` or `clear` is dropped.
- Asserting `rst_n` low mid-count immediately forces the reset values. No `done` is produced.

## Configuration
- Macro `COUNTDOWN_AUTORELOAD_EN`.
- **Defined:**
  - At 00:01 → 00:00 the block pulses `done` but stays in RUN.
  - The next tick loads the preset into the count instead of decrementing.
  - The period is therefore preset + 1 ticks.
  - If the preset is 00:00, the FSM goes to DONE instead.
- **Undefined:** the block behaves as described in Operation (RUN → DONE) and the preset is used only by load.

## Structure
- **Shared package (`pengtimer_pkg`):** the FSM state enum, the constants `SEC_TENS_MAX` = 5 and `DIGIT_MAX` = 9, and the BCD digit typedef.
- **Sub-module `bcd_down_mod60`:**
  - Ports: inputs `dec` and `load`; 4-bit tens and units inputs; outputs `zero` (value is 00) and `borrow` (registered underflow from 00).
  - Instantiated twice: seconds with a wrap tens of 5, and minutes with a parameterised wrap.
  - The minute borrow is never consumed, because the FSM stops at 00:00.

## Test plan
- Load 01:00, start, 1 tick → 00:59. Then 58 more ticks → 00:01. One more tick → 00:00 with `done` high for 1 cycle, state DONE and `running` = 0.
- Load 10:00, start, 1 tick → 09:59. This exercises the full borrow chain across every digit.
- Load with `ld_sec_t` = 6 → `load_err` pulses and the count is unchanged. Load 60:00 with `MIN_MAX` = 59 → `load_err` pulses.
- RUN at 00:30, `pause` together with `tick` → count stays 00:30 and `paused` = 1. Then 5 ticks → no change. Then `start` → RUN.
- RUN at 00:05, `clear` and `load` asserted in the same cycle → IDLE with count 00:00 (clear wins). `start` afterwards is ignored.
- With `COUNTDOWN_AUTORELOAD_EN` defined: load 00:02, start, 2 ticks → 00:00 with `done` pulsing and still RUN. Third tick → 00:02.

Source files
------------

// File: rtl/pengtimer_pkg.sv
// pengtimer_pkg: shared state enum, BCD digit type and digit limits for the timer blocks
package pengtimer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX = 4'd9;
endpackage

// File: rtl/countdown_mmss_if.sv
// countdown_mmss_if: control, load-digit and count/status bundle of the MM:SS countdown
interface countdown_mmss_if;
  import pengtimer_pkg::*;
  logic tick, load, start, pause, clear;
  bcd_t ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;
  bcd_t min_q1, min_q2, sec_q1, sec_q2;
  logic running, paused, done, load_err;
  modport master (
    output tick, load, start, pause, clear, ld_min_t, ld_min_u, ld_sec_t, ld_sec_u,
    input min_q1, min_q2, sec_q1, sec_q2, running, paused, done, load_err
  );
  modport slave (
    input tick, load, start, pause, clear, ld_min_t, ld_min_u, ld_sec_t, ld_sec_u,
    output min_q1, min_q2, sec_q1, sec_q2, running, paused, done, load_err
  );
endinterface

// File: rtl/bcd_down_mod60.sv
// bcd_down_mod60: loadable two-digit BCD down counter, units wrap 0->9, tens wrap 0->TENS_WRAP
module bcd_down_mod60 import pengtimer_pkg::*; #(
  parameter bcd_t TENS_WRAP = SEC_TENS_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec,
  input  logic load,
  input  bcd_t ld_t,
  input  bcd_t ld_u,
  output bcd_t q_t,
  output bcd_t q_u,
  output logic zero,
  output logic borrow
);
  assign zero = q_t == 4'd0 && q_u == 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_t <= 4'd0;
      q_u <= 4'd0;
      borrow <= 1'b0;
    end else begin
      borrow <= dec && !load && zero;
      if (load) begin
        q_t <= ld_t;
        q_u <= ld_u;
      end else if (dec) begin
        q_u <= q_u == 4'd0 ? DIGIT_MAX : q_u - 4'd1;
        if (q_u == 4'd0) q_t <= q_t == 4'd0 ? TENS_WRAP : q_t - 4'd1;
      end
    end
endmodule

// File: rtl/countdown_mmss.sv
// countdown_mmss: loadable BCD MM:SS countdown with IDLE/RUN/PAUSE/DONE control FSM
// Define COUNTDOWN_AUTORELOAD_EN to reload the preset on the tick after reaching 00:00.
module countdown_mmss import pengtimer_pkg::*; #(
  parameter int MIN_MAX = 59
) (
  input logic clk,
  input logic rst_n,
  countdown_mmss_if.slave bus
);
  state_t state, nxt;
  logic [15:0] ld_in, ld_val;
  logic cnt_load, dec, done_d, err_d, valid, sec_zero, min_zero, cnt_zero, cnt_one;
  logic unused_sec_borrow, unused_min_borrow;
  int min_bin;
  assign ld_in = {bus.ld_min_t, bus.ld_min_u, bus.ld_sec_t, bus.ld_sec_u};
  assign min_bin = 10 * int'(bus.ld_min_t) + int'(bus.ld_min_u);
  assign valid = bus.ld_min_t <= DIGIT_MAX && bus.ld_min_u <= DIGIT_MAX &&
                 bus.ld_sec_t <= SEC_TENS_MAX && bus.ld_sec_u <= DIGIT_MAX && min_bin <= MIN_MAX;
  assign cnt_zero = sec_zero && min_zero;
  assign cnt_one = min_zero && bus.sec_q1 == 4'd0 && bus.sec_q2 == 4'd1;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [15:0] preset;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) preset <= 16'h0;
    else if (!bus.clear && bus.load && state != RUN && valid) preset <= ld_in;
`endif
  always_comb begin
    nxt = state;
    cnt_load = 1'b0;
    ld_val = 16'h0;
    dec = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (bus.clear) begin
      nxt = IDLE;
      cnt_load = 1'b1;
    end else if (bus.load) begin
      if (state != RUN) begin
        nxt = valid ? IDLE : state;
        cnt_load = valid;
        ld_val = ld_in;
        err_d = !valid;
      end
    end else if (bus.pause) nxt = state == RUN ? PAUSE : state;
    else if (bus.start) nxt = (state == IDLE || state == PAUSE) && !cnt_zero ? RUN : state;
    else if (bus.tick && state == RUN) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      cnt_load = cnt_zero;
      ld_val = preset;
      dec = !cnt_zero;
      done_d = cnt_one;
      nxt = cnt_one && preset == 16'h0 ? DONE : RUN;
`else
      dec = 1'b1;
      done_d = cnt_one;
      nxt = cnt_one ? DONE : RUN;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.running <= 1'b0;
      bus.paused <= 1'b0;
      bus.done <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      state <= nxt;
      bus.running <= nxt == RUN;
      bus.paused <= nxt == PAUSE;
      bus.done <= done_d;
      bus.load_err <= err_d;
    end
  bcd_down_mod60 #(.TENS_WRAP(SEC_TENS_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .dec(dec), .load(cnt_load),
    .ld_t(ld_val[7:4]), .ld_u(ld_val[3:0]),
    .q_t(bus.sec_q1), .q_u(bus.sec_q2), .zero(sec_zero), .borrow(unused_sec_borrow)
  );
  bcd_down_mod60 #(.TENS_WRAP(DIGIT_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .dec(dec && sec_zero), .load(cnt_load),
    .ld_t(ld_val[15:12]), .ld_u(ld_val[11:8]),
    .q_t(bus.min_q1), .q_u(bus.min_q2), .zero(min_zero), .borrow(unused_min_borrow)
  );
endmodule

// File: tb/tb_countdown_mmss.sv
// tb_countdown_mmss: directed and random checks of countdown_mmss against a seconds-based model
module tb_countdown_mmss;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  int m_pre = 0;
  int m_st = 0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  countdown_mmss_if bus ();
  countdown_mmss dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int secs);
    int mn, sc;
    mn = secs / 60;
    sc = secs % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic logic [15:0] obs_cnt();
    return {bus.min_q1, bus.min_q2, bus.sec_q1, bus.sec_q2};
  endfunction

  task automatic check(input string tag);
    logic [15:0] oc;
    logic [3:0] of, ef;
    oc = obs_cnt();
    of = {bus.running, bus.paused, bus.done, bus.load_err};
    ef = {m_st == 1, m_st == 2, m_done, m_err};
    tests++;
    assert (oc === to_bcd(m_cnt)) else begin
      fails++;
      $error("FAIL %s count observed=%h expected=%h", tag, oc, to_bcd(m_cnt));
    end
    tests++;
    assert (of === ef) else begin
      fails++;
      $error("FAIL %s run/pause/done/err observed=%b expected=%b", tag, of, ef);
    end
  endtask

  task automatic expect_cnt(input string tag, input logic [15:0] exp);
    tests++;
    assert (obs_cnt() === exp) else begin
      fails++;
      $error("FAIL %s count observed=%h expected=%h", tag, obs_cnt(), exp);
    end
  endtask

  task automatic expect_flags(input string tag, input logic [3:0] exp);
    logic [3:0] of;
    of = {bus.running, bus.paused, bus.done, bus.load_err};
    tests++;
    assert (of === exp) else begin
      fails++;
      $error("FAIL %s run/pause/done/err observed=%b expected=%b", tag, of, exp);
    end
  endtask

  task automatic model(input bit c, l, p, s, t, input logic [15:0] ld);
    int mt, mu, st, su;
    {mt, mu, st, su} = {28'd0, ld[15:12], 28'd0, ld[11:8], 28'd0, ld[7:4], 28'd0, ld[3:0]};
    m_done = 1'b0;
    m_err = 1'b0;
    if (c) begin
      m_st = 0;
      m_cnt = 0;
    end else if (l) begin
      if (m_st != 1) begin
        if (mt <= 9 && mu <= 9 && st <= 5 && su <= 9 && mt * 10 + mu <= 59) begin
          m_cnt = (mt * 10 + mu) * 60 + st * 10 + su;
          m_pre = m_cnt;
          m_st = 0;
        end else m_err = 1'b1;
      end
    end else if (p) begin
      if (m_st == 1) m_st = 2;
    end else if (s) begin
      if ((m_st == 0 || m_st == 2) && m_cnt != 0) m_st = 1;
    end else if (t && m_st == 1) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      if (m_cnt == 0) m_cnt = m_pre;
      else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          if (m_pre == 0) m_st = 3;
        end
      end
`else
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_st = 3;
      end
`endif
    end
  endtask

  task automatic step(input string tag, input bit c, l, p, s, t, input logic [15:0] ld = 16'h0);
    {bus.clear, bus.load, bus.pause, bus.start, bus.tick} = {c, l, p, s, t};
    {bus.ld_min_t, bus.ld_min_u, bus.ld_sec_t, bus.ld_sec_u} = ld;
    @(posedge clk);
    model(c, l, p, s, t, ld);
    #1;
    check(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 1);
  endtask

  initial begin
    {bus.clear, bus.load, bus.pause, bus.start, bus.tick} = '0;
    {bus.ld_min_t, bus.ld_min_u, bus.ld_sec_t, bus.ld_sec_u} = '0;
    #2;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 0);
    step("start_zero", 0, 0, 0, 1, 0);
    expect_flags("start_zero_idle", 4'b0000);
    step("load_0100", 0, 1, 0, 0, 0, 16'h0100);
    step("start_tick", 0, 0, 0, 1, 1);
    expect_cnt("start_tick_no_dec", 16'h0100);
    step("tick1", 0, 0, 0, 0, 1);
    expect_cnt("first_dec", 16'h0059);
    ticks("run58", 58);
    expect_cnt("at_0001", 16'h0001);
    step("terminal", 0, 0, 0, 0, 1);
    expect_cnt("terminal_cnt", 16'h0000);
`ifdef COUNTDOWN_AUTORELOAD_EN
    expect_flags("terminal_flags", 4'b1010);
    step("reload", 0, 0, 0, 0, 1);
    expect_cnt("reload_cnt", 16'h0100);
    step("clr_ar", 1, 0, 0, 0, 0);
`else
    expect_flags("terminal_flags", 4'b0010);
    step("after_done", 0, 0, 0, 0, 1);
    expect_flags("done_one_cycle", 4'b0000);
    step("start_in_done", 0, 0, 0, 1, 0);
`endif
    step("load_1000", 0, 1, 0, 0, 0, 16'h1000);
    step("start_1000", 0, 0, 0, 1, 0);
    step("borrow_all", 0, 0, 0, 0, 1);
    expect_cnt("borrow_chain", 16'h0959);
    step("load_in_run", 0, 1, 0, 0, 0, 16'h0123);
    expect_flags("load_in_run_ignored", 4'b1000);
    step("pause_a", 0, 0, 1, 0, 0);
    step("bad_sec_t", 0, 1, 0, 0, 0, 16'h0160);
    expect_flags("bad_sec_t_err", 4'b0101);
    expect_cnt("bad_sec_t_cnt", 16'h0959);
    step("bad_min", 0, 1, 0, 0, 0, 16'h6000);
    expect_flags("bad_min_err", 4'b0101);
    step("bad_digit", 0, 1, 0, 0, 0, 16'h00a0);
    step("load_0030", 0, 1, 0, 0, 0, 16'h0030);
    step("start_0030", 0, 0, 0, 1, 0);
    step("pause_tick", 0, 0, 1, 0, 1);
    expect_cnt("pause_tick_cnt", 16'h0030);
    ticks("paused_ticks", 5);
    expect_cnt("paused_hold", 16'h0030);
    step("resume", 0, 0, 0, 1, 0);
    expect_flags("resumed", 4'b1000);
    step("load_0005", 0, 0, 1, 0, 0);
    step("load_0005b", 0, 1, 0, 0, 0, 16'h0005);
    step("start_0005", 0, 0, 0, 1, 0);
    step("clear_load", 1, 1, 0, 0, 1, 16'h0200);
    expect_cnt("clear_wins", 16'h0000);
    step("start_after_clear", 0, 0, 0, 1, 0);
    expect_flags("start_after_clear", 4'b0000);
`ifdef COUNTDOWN_AUTORELOAD_EN
    step("ar_load", 0, 1, 0, 0, 0, 16'h0002);
    step("ar_start", 0, 0, 0, 1, 0);
    ticks("ar_ticks", 2);
    expect_cnt("ar_zero", 16'h0000);
    expect_flags("ar_done_run", 4'b1010);
    step("ar_third", 0, 0, 0, 0, 1);
    expect_cnt("ar_reloaded", 16'h0002);
`endif
    step("rst_load", 0, 1, 0, 0, 0, 16'h0005);
    step("rst_start", 0, 0, 0, 1, 0);
    ticks("rst_ticks", 2);
    rst_n = 1'b0;
    #1;
    m_cnt = 0;
    m_pre = 0;
    m_st = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ticks("post_reset", 4);
    for (int i = 0; i < 3000; i++) begin
      bit c, l, p, s, t;
      logic [15:0] ld;
      c = $urandom_range(0, 99) < 2;
      l = $urandom_range(0, 99) < 6;
      p = $urandom_range(0, 99) < 4;
      s = $urandom_range(0, 99) < 10;
      t = $urandom_range(0, 99) < 75;
      ld = {($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
            4'($urandom_range(0, 1)), 4'($urandom_range(0, 6)),
            ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9))};
      step("random", c, l, p, s, t, ld);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
